// File: rtl/bf_tape_ram.sv
// -----------------------------------------------------------------------------
// bf_tape_ram
//
// Data-tape memory for the BrainFuzz interpreter core. The block holds a
// DEPTH x DATA_W single-port cell array, a tape pointer and a shadow copy of
// the cell under the pointer. The execute stage issues one command at a time
// over a valid/ready handshake and branches on the zero flag.
//
// Parameters
//   DATA_W    cell width in bits
//   ADDR_W    pointer width, DEPTH = 2**ADDR_W cells
//   INIT_VAL  value written to every cell by a sweep, and the reset value of
//             the shadow cell
//
// Ports
//   clk        in   rising-edge clock
//   rstb       in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle (IDLE only)
//   cmd_op     in   0 NOP, 1 RIGHT, 2 LEFT, 3 INC, 4 DEC, 5 READ, 6 WRITE,
//                   7 CLEAR
//   wr_data    in   data for WRITE
//   rsp_valid  out  one-cycle pulse when a command completes
//   rd_data    out  shadow of the current cell
//   ptr        out  tape pointer
//   zero       out  rd_data == 0
//
// Build option
//   BF_TAPE_CLEAR_EN  when defined, the sweep counter is built in: reset and
//                     CLEAR both write INIT_VAL to every cell, one per clock.
//                     When undefined there is no sweep hardware, reset
//                     reloads the shadow from cell 0 and CLEAR completes as a
//                     one-cycle NOP. Cell contents are not touched by reset
//                     in that build, so the execute stage has to write a cell
//                     before relying on its value.
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_SWEEP | writing INIT_VAL to cell sweep_cnt_q, last cell returns to IDLE
// ST_FETCH | loading the shadow from the cell under the (new) pointer
// ST_IDLE  | shadow equals mem[ptr], commands accepted
//
module bf_tape_ram #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              zero
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RIGHT = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_DEC   = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;
    localparam logic [2:0] OP_WRITE = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_FETCH = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

`ifdef BF_TAPE_CLEAR_EN
    localparam state_t RST_STATE = ST_SWEEP;
`else
    localparam state_t RST_STATE = ST_FETCH;
`endif

    state_t            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              fetch_rsp_q;   // FETCH was entered by a move, not by reset
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] cell_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef BF_TAPE_CLEAR_EN
    logic [ADDR_W-1:0] sweep_cnt_q;
    logic              sweep_rsp_q;   // sweep was started by CLEAR, not by reset
`endif

    assign accept = cmd_valid & cmd_ready_q;

    // Single write port. The value written for INC/DEC/WRITE is also the new
    // shadow value, so cell_q and mem[ptr] change on the same edge and a
    // back-to-back INC sees the updated shadow without any bypass.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = cell_q;
`ifdef BF_TAPE_CLEAR_EN
        if (state_q == ST_SWEEP) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_cnt_q;
            mem_wdata = INIT_VAL;
        end else if (accept) begin
`else
        if (accept) begin
`endif
            case (cmd_op)
                OP_INC: begin
                    mem_we    = 1'b1;
                    mem_wdata = cell_q + DATA_W'(1);
                end
                OP_DEC: begin
                    mem_we    = 1'b1;
                    mem_wdata = cell_q - DATA_W'(1);
                end
                OP_WRITE: begin
                    mem_we    = 1'b1;
                    mem_wdata = wr_data;
                end
                default: ;
            endcase
        end
    end

    // The array has no reset: contents survive rstb, only the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RST_STATE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            fetch_rsp_q <= 1'b0;
            ptr_q       <= '0;
            cell_q      <= INIT_VAL;
`ifdef BF_TAPE_CLEAR_EN
            sweep_cnt_q <= '0;
            sweep_rsp_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
`ifdef BF_TAPE_CLEAR_EN
                ST_SWEEP: begin
                    sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    if (&sweep_cnt_q) begin
                        // Counter wraps back to 0 here, ready for the next sweep.
                        cell_q      <= INIT_VAL;
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= sweep_rsp_q;
                        sweep_rsp_q <= 1'b0;
                    end
                end
`endif
                ST_FETCH: begin
                    cell_q      <= mem[ptr_q];
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= fetch_rsp_q;
                    fetch_rsp_q <= 1'b0;
                end
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_RIGHT: begin
                                ptr_q       <= ptr_q + 1'b1;
                                state_q     <= ST_FETCH;
                                cmd_ready_q <= 1'b0;
                                fetch_rsp_q <= 1'b1;
                            end
                            OP_LEFT: begin
                                ptr_q       <= ptr_q - 1'b1;
                                state_q     <= ST_FETCH;
                                cmd_ready_q <= 1'b0;
                                fetch_rsp_q <= 1'b1;
                            end
                            OP_INC, OP_DEC, OP_WRITE: begin
                                cell_q      <= mem_wdata;
                                rsp_valid_q <= 1'b1;
                            end
                            OP_NOP, OP_READ: begin
                                rsp_valid_q <= 1'b1;
                            end
                            OP_CLEAR: begin
`ifdef BF_TAPE_CLEAR_EN
                                state_q     <= ST_SWEEP;
                                cmd_ready_q <= 1'b0;
                                sweep_cnt_q <= '0;
                                sweep_rsp_q <= 1'b1;
`else
                                rsp_valid_q <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Unreachable encoding: resynchronise the shadow.
                    state_q     <= ST_FETCH;
                    cmd_ready_q <= 1'b0;
                    fetch_rsp_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rd_data   = cell_q;
    assign ptr       = ptr_q;
    assign zero      = (cell_q == '0);

endmodule

// File: tb/tb_bf_tape_ram.sv
module tb_bf_tape_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

`ifdef BF_TAPE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int RST_EDGES = CLR_EN ? DEPTH : 1;
    localparam int CLR_LAT   = CLR_EN ? DEPTH + 1 : 1;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] RIGHT = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] INC   = 3'd3;
    localparam logic [2:0] DEC   = 3'd4;
    localparam logic [2:0] READ  = 3'd5;
    localparam logic [2:0] WRITE = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [DW-1:0] wr_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ptr;
    logic          zero;

    bf_tape_ram #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .INIT_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rd_data   (rd_data),
        .ptr       (ptr),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] rd;
        logic [AW-1:0] p;
        int            lat;
        int            acc;
        bit            chk_rd;
        int            id;
    } exp_t;

    exp_t sb[$];
    int   n_issued = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstb && rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected rsp_valid", rsp_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    if (e.chk_rd) begin
                        check($sformatf("rsp%0d rd_data", e.id), rd_data, e.rd);
                        check($sformatf("rsp%0d zero", e.id), zero, (e.rd == '0));
                    end
                    check($sformatf("rsp%0d ptr", e.id), ptr, e.p);
                    check($sformatf("rsp%0d latency", e.id), cyc - e.acc + 1, e.lat);
                    check($sformatf("rsp%0d cmd_ready", e.id), cmd_ready, 1'b1);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input logic [AW-1:0] p,
                         input int lat, input bit chk_rd);
        int   waited;
        exp_t e;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        wr_data   = wd;
        while (!cmd_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check($sformatf("cmd%0d cmd_ready timeout", n_issued), cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        e.rd     = rd;
        e.p      = p;
        e.lat    = lat;
        e.acc    = cyc + 1;
        e.chk_rd = chk_rd;
        e.id     = n_issued;
        sb.push_back(e);
        n_issued++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, " scoreboard drained"}, sb.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1'b0);
        check({tag, " rsp_valid"}, rsp_valid, 1'b0);
        check({tag, " ptr"}, ptr, 4'd0);
        check({tag, " rd_data"}, rd_data, 8'h00);
        check({tag, " zero"}, zero, 1'b1);
    endtask

    // Called at a negedge with rstb low; releases and times the init phase.
    task automatic release_reset(input string tag);
        int n;
        bit saw_rsp;
        n       = 0;
        saw_rsp = 1'b0;
        rstb    = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check({tag, " edges to cmd_ready"}, n, RST_EDGES);
        check({tag, " rsp_valid during init"}, saw_rsp, 1'b0);
        check({tag, " ptr after init"}, ptr, 4'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic [AW-1:0] p;
        int            lat;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [2:0] op, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rd, input logic [AW-1:0] p,
                                input int lat);
        vec_t v;
        v.op  = op;
        v.wd  = wd;
        v.rd  = rd;
        v.p   = p;
        v.lat = lat;
        vt.push_back(v);
    endfunction

    logic [DW-1:0] model [DEPTH];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Back-to-back INC/DEC with wrap at 0, then moves and wraps.
        add(INC,   8'h00, 8'h01, 4'd0,  1);
        add(INC,   8'h00, 8'h02, 4'd0,  1);
        add(INC,   8'h00, 8'h03, 4'd0,  1);
        add(DEC,   8'h00, 8'h02, 4'd0,  1);
        add(DEC,   8'h00, 8'h01, 4'd0,  1);
        add(DEC,   8'h00, 8'h00, 4'd0,  1);
        add(DEC,   8'h00, 8'hFF, 4'd0,  1);
        add(WRITE, 8'hA5, 8'hA5, 4'd0,  1);
        add(RIGHT, 8'h00, 8'h00, 4'd1,  2);
        add(WRITE, 8'h3C, 8'h3C, 4'd1,  1);
        add(LEFT,  8'h00, 8'hA5, 4'd0,  2);
        add(LEFT,  8'h00, 8'h00, 4'd15, 2);
        add(WRITE, 8'h77, 8'h77, 4'd15, 1);
        add(RIGHT, 8'h00, 8'hA5, 4'd0,  2);
        add(LEFT,  8'h00, 8'h77, 4'd15, 2);
        add(RIGHT, 8'h00, 8'hA5, 4'd0,  2);
        add(WRITE, 8'hFF, 8'hFF, 4'd0,  1);
        add(INC,   8'h00, 8'h00, 4'd0,  1);
        add(DEC,   8'h00, 8'hFF, 4'd0,  1);
        add(INC,   8'h00, 8'h00, 4'd0,  1);
        add(READ,  8'h00, 8'h00, 4'd0,  1);
        add(NOP,   8'h00, 8'h00, 4'd0,  1);
        add(RIGHT, 8'h00, 8'h3C, 4'd1,  2);
        add(READ,  8'h00, 8'h3C, 4'd1,  1);
        add(CLEAR, 8'h00, CLR_EN ? 8'h00 : 8'h3C, 4'd1, CLR_LAT);
        add(READ,  8'h00, CLR_EN ? 8'h00 : 8'h3C, 4'd1, 1);
        add(LEFT,  8'h00, 8'h00, 4'd0,  2);
        add(LEFT,  8'h00, CLR_EN ? 8'h00 : 8'h77, 4'd15, 2);
        add(RIGHT, 8'h00, 8'h00, 4'd0,  2);

        // Reset state and init phase timing.
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        release_reset("power-up");
`ifdef BF_TAPE_CLEAR_EN
        check("power-up rd_data", rd_data, 8'h00);
        check("power-up zero", zero, 1'b1);
`endif

        // Bring every cell to a known 0, then read them all back.
        for (int i = 0; i < DEPTH; i++) begin
`ifdef BF_TAPE_CLEAR_EN
            issue(READ, 8'h00, 8'h00, 4'(i), 1, 1'b1);
`else
            issue(WRITE, 8'h00, 8'h00, 4'(i), 1, 1'b1);
`endif
            issue(RIGHT, 8'h00, 8'h00, 4'(i + 1), 2, CLR_EN);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(READ, 8'h00, 8'h00, 4'(i), 1, 1'b1);
            issue(RIGHT, 8'h00, 8'h00, 4'(i + 1), 2, 1'b1);
        end
        drain("init pass");

        for (int k = 0; k < vt.size(); k++) begin
            issue(vt[k].op, vt[k].wd, vt[k].rd, vt[k].p, vt[k].lat, 1'b1);
        end
        drain("table");

        // Whole-tape readback after CLEAR.
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        model[1]  = CLR_EN ? 8'h00 : 8'h3C;
        model[15] = CLR_EN ? 8'h00 : 8'h77;
        for (int i = 0; i < DEPTH; i++) begin
            issue(READ, 8'h00, model[i], 4'(i), 1, 1'b1);
            issue(RIGHT, 8'h00, model[(i + 1) % DEPTH], 4'(i + 1), 2, 1'b1);
        end
        drain("post-clear readback");

        // Reset during FETCH: pointer move must be undone, no response.
        issue(WRITE, 8'h42, 8'h42, 4'd0, 1, 1'b1);
        drain("pre-fetch-reset");
        check("mid-fetch ready before LEFT", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = LEFT;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid-fetch ptr moved", ptr, 4'd15);
        check("mid-fetch cmd_ready low", cmd_ready, 1'b0);
        rstb = 1'b0;
        #1;
        chk_reset_vals("mid-fetch reset");
        repeat (2) @(negedge clk);
        release_reset("after mid-fetch");
        check("after mid-fetch rd_data", rd_data, CLR_EN ? 8'h00 : 8'h42);
        issue(READ, 8'h00, CLR_EN ? 8'h00 : 8'h42, 4'd0, 1, 1'b1);
        drain("after mid-fetch");

`ifdef BF_TAPE_CLEAR_EN
        // Reset while the sweep is at address 7: sweep restarts from 0 and
        // must still reach the last cell.
        issue(LEFT,  8'h00, 8'h00, 4'd15, 2, 1'b1);
        issue(WRITE, 8'h5A, 8'h5A, 4'd15, 1, 1'b1);
        issue(RIGHT, 8'h00, 8'h00, 4'd0,  2, 1'b1);
        drain("pre-sweep-reset");
        check("mid-sweep ready before CLEAR", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = CLEAR;
        @(negedge clk);
        cmd_valid = 1'b0;
        begin
            int n_hi;
            n_hi = 0;
            repeat (7) begin
                if (cmd_ready) n_hi++;
                @(negedge clk);
            end
            check("mid-sweep cmd_ready stayed low", n_hi, 0);
        end
        rstb = 1'b0;
        #1;
        chk_reset_vals("mid-sweep reset");
        repeat (2) @(negedge clk);
        release_reset("after mid-sweep");
        issue(LEFT, 8'h00, 8'h00, 4'd15, 2, 1'b1);
        issue(RIGHT, 8'h00, 8'h00, 4'd0, 2, 1'b1);
        drain("after mid-sweep");
`endif

        repeat (4) @(negedge clk);
        check("final scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
